serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial two's-complement subtractor computing D = A - B, one bit per accepted cycle, LSB first.
//   It is the inverse operation of the team's full-adder datapath. It sits behind the tt_um
//   wrapper: operand bits arrive on ui_in and results leave on uo_out. One combinational 1-bit
//   full-subtractor cell plus a borrow flop, bit counter and result shift register are
//   sequenced by a 3-state FSM.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>=2); sets frame length and counter size
// PORTS
//   clk         in   1      single clock; all state updates on rising edge
//   rst         in   1      synchronous, active-high reset
//   start       in   1      begin a new frame; accepted only in IDLE
//   bit_valid   in   1      a_bit/b_bit valid this cycle; accepted only in RUN
//   a_bit       in   1      minuend bit, LSB first
//   b_bit       in   1      subtrahend bit, LSB first
//   diff_bit    out  1      registered difference bit for last accepted input bit
//   diff_valid  out  1      1-cycle pulse qualifying diff_bit
//   busy        out  1      1 in RUN
//   done        out  1      1-cycle pulse: frame complete, result/flags valid
//   result      out  WIDTH  parallel difference, held from done until next accepted start
//   borrow_out  out  1      final borrow (1 => A < B unsigned), held like result
//   ovf         out  1      signed overflow = borrow into MSB XOR borrow out of MSB, held
// BEHAVIOUR
//   Reset (rst=1 at edge, any state, incl. mid-frame): state=IDLE and every output = 0,
//     including result, borrow_out and ovf. The borrow flop and counter are also 0.
//   Cell: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
//   IDLE: busy=0. On start=1, go to RUN and set borrow=0, count=0, result=0.
//     bit_valid is ignored in IDLE.
//   RUN: busy=1.
//     - Each cycle with bit_valid=1:
//       - diff_bit <= d, diff_valid <= 1 (latency 1 cycle).
//       - borrow <= bout.
//       - result <= {d, result[WIDTH-1:1]} (shift right; LSB ends at bit 0).
//       - count <= count+1.
//     - bit_valid=0 stalls: borrow, count and result hold; diff_valid=0.
//     - start in RUN is ignored; it does not restart the frame.
//     - On an accepted bit with count==WIDTH-1:
//       - borrow_out <= bout, ovf <= bin ^ bout.
//       - go to DONE.
//   DONE: lasts exactly 1 cycle.
//     - done=1, busy=0; this is the same cycle in which the final diff_valid=1 is seen.
//     - start and bit_valid are ignored.
//     - Next state is IDLE.
//   result, borrow_out and ovf hold their values after DONE until the next accepted start
//     clears them.
//   Width rules: count is $clog2(WIDTH) bits and never wraps within a frame.
//     Arithmetic is modulo 2^WIDTH.
//   Simultaneous start and bit_valid in IDLE: start is taken, the bit is dropped.
//     The first data bit is accepted at the earliest one cycle after start.
// STRUCTURE
//   Package serial_sub_pkg:
//     - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2
//     - default WIDTH constant
//   Sub-module full_subtractor_cell: combinational, ports a, b, bin, d, bout.
//     It mirrors the team's 1-bit full adder and is instantiated once.
//   Top: FSM, counter, borrow flop, result shift register, output flops.
//     All sequential logic sits in one clocked process with synchronous rst.
// TESTING (WIDTH=8)
//   1. Basic subtraction: A=0x5A, B=0x23, 8 back-to-back bits.
//      -> result=0x37, borrow_out=0, ovf=0, done pulses 1 cycle after the 8th bit.
//   2. Unsigned borrow: A=0x10, B=0x20.
//      -> result=0xF0, borrow_out=1, ovf=0.
//   3. Signed overflow: A=0x80, B=0x01.
//      -> result=0x7F, borrow_out=0, ovf=1; also 0x7F-0xFF -> 0x80, borrow_out=1, ovf=1.
//   4. Stalls: case 1 with bit_valid=0 gaps of 1-3 cycles between bits.
//      -> identical result and flags; diff_valid count = 8; busy=1 throughout.
//   5. Control robustness:
//      - rst after 4 bits -> all outputs 0 next cycle, IDLE.
//      - start pulsed during RUN -> frame unaffected.
//      - bit_valid in IDLE -> no diff_valid.
//   6. Frame-to-frame: new start after done.
//      -> result/borrow_out/ovf cleared on the start edge; the second frame A=0xFF, B=0xFF
//         gives result 0x00, borrow_out=0, ovf=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Imported by the top level and the testbench.
package serial_sub_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Frame control, serial data and result bundle.
// master drives operands, slave is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic             bit_valid;
  logic             a_bit;
  logic             b_bit;
  logic             diff_bit;
  logic             diff_valid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             borrow_out;
  logic             ovf;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  diff_bit, diff_valid, busy, done,
    input  result, borrow_out, ovf
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output diff_bit, diff_valid, busy, done,
    output result, borrow_out, ovf
  );

endinterface

// File: rtl/full_subtractor_cell.sv
// 1-bit full subtractor: d = a - b - bin.
// Counterpart of the 1-bit full adder cell.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // difference and borrow out of this bit position
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor D = A - B,
// LSB first, one bit per accepted cycle.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic             r_borrow;
  logic [WIDTH-1:0] r_result;
  logic             r_diff_bit;
  logic             r_diff_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_borrow_out;
  logic             r_ovf;

  logic             w_d;
  logic             w_bout;

  full_subtractor_cell u_cell (
    .a    (bus.a_bit),
    .b    (bus.b_bit),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // frame FSM, bit counter, borrow chain and result shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_borrow     <= 1'b0;
      r_result     <= '0;
      r_diff_bit   <= 1'b0;
      r_diff_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_borrow_out <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_diff_valid <= 1'b0;
      r_done       <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state      <= RUN;
            r_busy       <= 1'b1;
            r_count      <= '0;
            r_borrow     <= 1'b0;
            r_result     <= '0;
            r_borrow_out <= 1'b0;
            r_ovf        <= 1'b0;
          end
        end
        RUN: begin
          if (bus.bit_valid) begin
            r_diff_bit   <= w_d;
            r_diff_valid <= 1'b1;
            r_borrow     <= w_bout;
            r_result     <= {w_d, r_result[WIDTH-1:1]};
            if (r_count == LAST) begin
              // MSB: borrow in vs out gives signed overflow
              r_count      <= '0;
              r_borrow_out <= w_bout;
              r_ovf        <= r_borrow ^ w_bout;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.diff_bit   = r_diff_bit;
  assign bus.diff_valid = r_diff_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.result     = r_result;
  assign bus.borrow_out = r_borrow_out;
  assign bus.ovf        = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8),
// arithmetic reference model, randomized frames.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] r;
    logic         bo;
    logic         ov;
  } exp_t;

  logic clk;
  logic rst;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_dv     = 0;
  logic exp_bits[$];
  exp_t exp_frames[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    int   sd;
    sd   = int'($signed(a)) - int'($signed(b));
    e.r  = a - b;
    e.bo = (a < b);
    e.ov = (sd > 127) || (sd < -128);
    return e;
  endfunction

  // monitor: pop and compare whenever the DUT presents output
  always @(negedge clk) begin
    if (bus.diff_valid === 1'b1) begin
      n_dv++;
      if (exp_bits.size() == 0)
        chk("diff_valid with empty queue", 32'(bus.diff_valid), 0);
      else
        chk("diff_bit", 32'(bus.diff_bit), 32'(exp_bits.pop_front()));
    end
    if (bus.done === 1'b1) begin
      if (exp_frames.size() == 0) begin
        chk("done with empty queue", 32'(bus.done), 0);
      end else begin
        exp_t e;
        e = exp_frames.pop_front();
        chk("result", 32'(bus.result), 32'(e.r));
        chk("borrow_out", 32'(bus.borrow_out), 32'(e.bo));
        chk("ovf", 32'(bus.ovf), 32'(e.ov));
        chk("diff_valid with done", 32'(bus.diff_valid), 1);
        chk("busy in done", 32'(bus.busy), 0);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, " diff_bit"}, 32'(bus.diff_bit), 0);
    chk({tag, " diff_valid"}, 32'(bus.diff_valid), 0);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
    chk({tag, " result"}, 32'(bus.result), 0);
    chk({tag, " borrow_out"}, 32'(bus.borrow_out), 0);
    chk({tag, " ovf"}, 32'(bus.ovf), 0);
  endtask

  // one frame; called and returns #1 after a rising edge
  task automatic run_frame(input logic [W-1:0] a,
                           input logic [W-1:0] b,
                           input int gmin, input int gmax,
                           input bit start_mid,
                           input bit bv_with_start,
                           input int nbits);
    exp_t e;
    int   g;
    e = model(a, b);
    bus.start     = 1'b1;
    bus.bit_valid = bv_with_start;
    bus.a_bit     = ~a[0];
    bus.b_bit     = b[0];
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    chk("busy after start", 32'(bus.busy), 1);
    chk("result cleared on start", 32'(bus.result), 0);
    chk("borrow_out cleared", 32'(bus.borrow_out), 0);
    chk("ovf cleared", 32'(bus.ovf), 0);
    for (int i = 0; i < nbits; i++) exp_bits.push_back(e.r[i]);
    if (nbits == W) exp_frames.push_back(e);
    for (int i = 0; i < nbits; i++) begin
      g = $urandom_range(gmax, gmin);
      for (int k = 0; k < g; k++) begin
        bus.bit_valid = 1'b0;
        bus.a_bit     = 1'($urandom);
        bus.b_bit     = 1'($urandom);
        @(posedge clk); #1;
        chk("busy in stall", 32'(bus.busy), 1);
      end
      bus.bit_valid = 1'b1;
      bus.start     = start_mid && (i == 3);
      bus.a_bit     = a[i];
      bus.b_bit     = b[i];
      @(posedge clk); #1;
      bus.bit_valid = 1'b0;
      bus.start     = 1'b0;
      if (i < W - 1)
        chk("busy in run", 32'(bus.busy), 1);
    end
    if (nbits == W) begin
      chk("done after last bit", 32'(bus.done), 1);
      @(posedge clk); #1;
      chk("done one cycle", 32'(bus.done), 0);
      chk("busy idle", 32'(bus.busy), 0);
      chk("result held", 32'(bus.result), 32'(e.r));
      chk("borrow_out held", 32'(bus.borrow_out), 32'(e.bo));
      chk("ovf held", 32'(bus.ovf), 32'(e.ov));
    end
  endtask

  initial begin
    int dv0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.a_bit     = 1'b0;
    bus.b_bit     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(8'h5A, 8'h23, 0, 0, 0, 0, W);
    run_frame(8'h10, 8'h20, 0, 0, 0, 0, W);
    run_frame(8'h80, 8'h01, 0, 0, 0, 0, W);
    run_frame(8'h7F, 8'hFF, 0, 0, 0, 0, W);

    dv0 = n_dv;
    run_frame(8'h5A, 8'h23, 1, 3, 0, 0, W);
    @(posedge clk); #1;
    chk("stall diff_valid count", 32'(n_dv - dv0), W);

    run_frame(8'hC3, 8'h5E, 0, 1, 0, 0, 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero("mid-frame reset");
    chk("partial bits drained", 32'(exp_bits.size()), 0);
    @(posedge clk); #1;

    run_frame(8'h3C, 8'hA7, 0, 2, 1, 0, W);

    dv0 = n_dv;
    bus.bit_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.bit_valid = 1'b0;
    @(posedge clk); #1;
    chk("no diff_valid in idle", 32'(n_dv - dv0), 0);
    chk("idle busy", 32'(bus.busy), 0);

    run_frame(8'h5A, 8'h23, 0, 0, 0, 0, W);
    run_frame(8'hFF, 8'hFF, 0, 0, 0, 0, W);

    run_frame(8'h01, 8'h02, 0, 0, 0, 1, W);

    for (int n = 0; n < 20; n++) begin
      run_frame(8'($urandom), 8'($urandom), 0, $urandom_range(2, 0),
                1'($urandom), 1'($urandom), W);
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("bit queue empty", 32'(exp_bits.size()), 0);
    chk("frame queue empty", 32'(exp_frames.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
